// File: rtl/output_buff.sv
// output_buff: serialises four NDATA-bit words onto a 4-lane bit bus, LSB first.
// Latency: accept at edge k, transfer at k+1, bit 0 on dout after edge k+1; one bit per enabled cycle.
// Backpressure: ready = shadow empty; a load while ready=0 is ignored and must be held by the sender.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   ena             clock enable; every register holds while low
//   din0..din3      frame words for lanes 0..3
//   load / ready    frame offer / shadow register empty
//   dout            serial lanes, dout[i] = current bit of lane i
//   dout_valid      a frame bit is on dout
//   cntout          index of the bit on dout (0 when idle)
//   last            dout carries bit NDATA-1
module output_buff #(
    parameter int          NDATA    = 128,
    parameter logic [3:0]  IDLE_VAL = 4'b0001
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic [NDATA-1:0]           din0,
    input  logic [NDATA-1:0]           din1,
    input  logic [NDATA-1:0]           din2,
    input  logic [NDATA-1:0]           din3,
    input  logic                       load,
    output logic                       ready,
    output logic [3:0]                 dout,
    output logic                       dout_valid,
    output logic [$clog2(NDATA)-1:0]   cntout,
    output logic                       last
);

    localparam int NDATA_LOG = $clog2(NDATA);
    localparam logic [NDATA_LOG-1:0] CNT_MAX  = NDATA_LOG'(NDATA - 1);
    localparam logic [NDATA_LOG-1:0] CNT_PREV = NDATA_LOG'(NDATA - 2);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t                 state_q;
    logic                   shadow_full_q;
    logic [NDATA-1:0]       shadow0_q, shadow1_q, shadow2_q, shadow3_q;
    logic [NDATA-1:0]       act0_q, act1_q, act2_q, act3_q;
    logic [NDATA_LOG-1:0]   cnt_q;
    logic [3:0]             dout_q;
    logic                   dout_valid_q;
    logic                   last_q;

    logic                   accept_d;
    logic                   transfer_d;

    // Accept needs an empty shadow and transfer a full one, so the two
    // never fire on the same edge and the shadow has a single writer per edge.
    always_comb begin
        accept_d   = load && !shadow_full_q;
        transfer_d = shadow_full_q &&
                     ((state_q == S_IDLE) || ((state_q == S_SHIFT) && (cnt_q == CNT_MAX)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            shadow_full_q <= 1'b0;
            shadow0_q     <= '0;
            shadow1_q     <= '0;
            shadow2_q     <= '0;
            shadow3_q     <= '0;
            act0_q        <= '0;
            act1_q        <= '0;
            act2_q        <= '0;
            act3_q        <= '0;
            cnt_q         <= '0;
            dout_q        <= IDLE_VAL;
            dout_valid_q  <= 1'b0;
            last_q        <= 1'b0;
        end else if (ena) begin
            if (accept_d) begin
                shadow0_q     <= din0;
                shadow1_q     <= din1;
                shadow2_q     <= din2;
                shadow3_q     <= din3;
                shadow_full_q <= 1'b1;
            end

            if (transfer_d) begin
                // Bit 0 of the new frame goes straight onto dout; this is what
                // makes back-to-back frames seamless across the cnt wrap.
                act0_q        <= shadow0_q;
                act1_q        <= shadow1_q;
                act2_q        <= shadow2_q;
                act3_q        <= shadow3_q;
                shadow_full_q <= 1'b0;
                state_q       <= S_SHIFT;
                cnt_q         <= '0;
                dout_q        <= {shadow3_q[0], shadow2_q[0], shadow1_q[0], shadow0_q[0]};
                dout_valid_q  <= 1'b1;
                last_q        <= 1'b0;
            end else if (state_q == S_SHIFT) begin
                if (cnt_q == CNT_MAX) begin
                    state_q      <= S_IDLE;
                    cnt_q        <= '0;
                    dout_q       <= IDLE_VAL;
                    dout_valid_q <= 1'b0;
                    last_q       <= 1'b0;
                end else begin
                    // act*_q[0] always mirrors the bit on dout, so the next bit is [1].
                    act0_q       <= act0_q >> 1;
                    act1_q       <= act1_q >> 1;
                    act2_q       <= act2_q >> 1;
                    act3_q       <= act3_q >> 1;
                    cnt_q        <= cnt_q + 1'b1;
                    dout_q       <= {act3_q[1], act2_q[1], act1_q[1], act0_q[1]};
                    dout_valid_q <= 1'b1;
                    last_q       <= (cnt_q == CNT_PREV);
                end
            end
        end
    end

    assign ready      = !shadow_full_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign cntout     = cnt_q;
    assign last       = last_q;

endmodule

// File: tb/tb_output_buff.sv
module tb_output_buff;

    logic        clk;
    logic        rst;
    logic        ena;
    logic [7:0]  din0, din1, din2, din3;
    logic        load;
    logic        ready;
    logic [3:0]  dout;
    logic        dout_valid;
    logic [2:0]  cntout;
    logic        last;

    logic [127:0] lb_din0, lb_din1, lb_din2, lb_din3;
    logic         lb_load;
    logic         lb_ready;
    logic [3:0]   lb_dout;
    logic         lb_dout_valid;
    logic [6:0]   lb_cntout;
    logic         lb_last;
    logic         lb_ena;

    logic [127:0] rx0, rx1, rx2, rx3;

    int n_chk;
    int n_pass;

    output_buff #(.NDATA(8), .IDLE_VAL(4'b0001)) u_dut (
        .clk(clk), .rst(rst), .ena(ena),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .load(load), .ready(ready), .dout(dout), .dout_valid(dout_valid),
        .cntout(cntout), .last(last)
    );

    output_buff #(.NDATA(128), .IDLE_VAL(4'b0001)) u_lb (
        .clk(clk), .rst(rst), .ena(lb_ena),
        .din0(lb_din0), .din1(lb_din1), .din2(lb_din2), .din3(lb_din3),
        .load(lb_load), .ready(lb_ready), .dout(lb_dout), .dout_valid(lb_dout_valid),
        .cntout(lb_cntout), .last(lb_last)
    );

    // Behavioural 4-lane receive buffer: places each valid bit at cntin=cntout.
    always_ff @(posedge clk) begin
        if (lb_dout_valid) begin
            rx0[lb_cntout] <= lb_dout[0];
            rx1[lb_cntout] <= lb_dout[1];
            rx2[lb_cntout] <= lb_dout[2];
            rx3[lb_cntout] <= lb_dout[3];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_din(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
        din0 = a; din1 = b; din2 = c; din3 = d;
    endtask

    function automatic logic [3:0] bits8(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic [7:0] d, input int k);
        return {d[k], c[k], b[k], a[k]};
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_dout"},  128'(dout), 128'(4'b0001));
        chk({tag, "_valid"}, 128'(dout_valid), 128'(1'b0));
        chk({tag, "_cnt"},   128'(cntout), 128'(3'd0));
        chk({tag, "_last"},  128'(last), 128'(1'b0));
    endtask

    // Hand-computed lane bits for din0=A5, din1=0F, din2=FF, din3=00, as dout[3:0].
    logic [3:0] tbl1 [8];

    initial begin
        int t;
        int seen;
        n_chk = 0; n_pass = 0;
        tbl1[0] = 4'h7; tbl1[1] = 4'h6; tbl1[2] = 4'h7; tbl1[3] = 4'h6;
        tbl1[4] = 4'h4; tbl1[5] = 4'h5; tbl1[6] = 4'h4; tbl1[7] = 4'h5;

        rst = 1'b1; ena = 1'b1; load = 1'b0; set_din(8'h00, 8'h00, 8'h00, 8'h00);
        lb_ena = 1'b1; lb_load = 1'b0;
        lb_din0 = '0; lb_din1 = '0; lb_din2 = '0; lb_din3 = '0;
        #12;
        chk_idle("rst");
        chk("rst_ready", 128'(ready), 128'(1'b1));
        rst = 1'b0;
        tick();

        // Single frame with table-driven expectations.
        set_din(8'hA5, 8'h0F, 8'hFF, 8'h00); load = 1'b1;
        tick();
        chk("t1_ready_drop", 128'(ready), 128'(1'b0));
        chk("t1_not_yet_valid", 128'(dout_valid), 128'(1'b0));
        load = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t1_dout%0d", k), 128'(dout), 128'(tbl1[k]));
            chk($sformatf("t1_cnt%0d", k), 128'(cntout), 128'(k));
            chk($sformatf("t1_last%0d", k), 128'(last), 128'(k == 7));
            chk($sformatf("t1_valid%0d", k), 128'(dout_valid), 128'(1'b1));
            tick();
        end
        chk_idle("t1_end");
        chk("t1_end_ready", 128'(ready), 128'(1'b1));

        // Back-to-back: second frame offered at cntout=3.
        set_din(8'hA5, 8'h0F, 8'hFF, 8'h00); load = 1'b1;
        tick(); load = 1'b0; tick();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t2a_dout%0d", k), 128'(dout), 128'(tbl1[k]));
            chk($sformatf("t2a_valid%0d", k), 128'(dout_valid), 128'(1'b1));
            if (k == 3) begin
                set_din(8'hFF, 8'h3C, 8'hC3, 8'h81); load = 1'b1;
            end
            if (k == 4) begin
                chk("t2_ready_low", 128'(ready), 128'(1'b0));
                load = 1'b0; set_din(8'h00, 8'h00, 8'h00, 8'h00);
            end
            tick();
        end
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t2b_dout%0d", k), 128'(dout), 128'(bits8(8'hFF, 8'h3C, 8'hC3, 8'h81, k)));
            chk($sformatf("t2b_cnt%0d", k), 128'(cntout), 128'(k));
            chk($sformatf("t2b_valid%0d", k), 128'(dout_valid), 128'(1'b1));
            if (k == 0) chk("t2_ready_back", 128'(ready), 128'(1'b1));
            tick();
        end
        chk_idle("t2_end");

        // Clock-enable freeze at cntout=4.
        set_din(8'hC3, 8'h5A, 8'h96, 8'hE1); load = 1'b1;
        tick(); load = 1'b0; tick();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t3_dout%0d", k), 128'(dout), 128'(bits8(8'hC3, 8'h5A, 8'h96, 8'hE1, k)));
            chk($sformatf("t3_cnt%0d", k), 128'(cntout), 128'(k));
            chk($sformatf("t3_last%0d", k), 128'(last), 128'(k == 7));
            if (k == 4) begin
                ena = 1'b0;
                set_din(8'h11, 8'h22, 8'h33, 8'h44); load = 1'b1;
                for (int j = 0; j < 3; j++) begin
                    tick();
                    chk($sformatf("t3_frz_dout%0d", j), 128'(dout), 128'(bits8(8'hC3, 8'h5A, 8'h96, 8'hE1, 4)));
                    chk($sformatf("t3_frz_cnt%0d", j), 128'(cntout), 128'(3'd4));
                    chk($sformatf("t3_frz_last%0d", j), 128'(last), 128'(1'b0));
                    chk($sformatf("t3_frz_ready%0d", j), 128'(ready), 128'(1'b1));
                end
                load = 1'b0;
                ena = 1'b1;
            end
            tick();
        end
        chk_idle("t3_end");
        chk("t3_end_ready", 128'(ready), 128'(1'b1));

        // Load held while shadow full: only the first offered frame is queued.
        set_din(8'h5A, 8'hA5, 8'h0F, 8'hF0); load = 1'b1;
        tick(); load = 1'b0; tick();
        set_din(8'h81, 8'h42, 8'h24, 8'h18); load = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t4a_dout%0d", k), 128'(dout), 128'(bits8(8'h5A, 8'hA5, 8'h0F, 8'hF0, k)));
            if (k == 1) set_din(8'h6B, 8'h9D, 8'hE7, 8'h3C);
            if (k >= 2 && k <= 6) chk($sformatf("t4_ready_low%0d", k), 128'(ready), 128'(1'b0));
            if (k == 6) load = 1'b0;
            tick();
        end
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t4b_dout%0d", k), 128'(dout), 128'(bits8(8'h81, 8'h42, 8'h24, 8'h18, k)));
            tick();
        end
        chk_idle("t4_end");

        // Asynchronous reset at cntout=5 with the shadow full.
        set_din(8'hFF, 8'hFF, 8'hFF, 8'hFF); load = 1'b1;
        tick(); load = 1'b0; tick();
        set_din(8'hAA, 8'h55, 8'hAA, 8'h55); load = 1'b1;
        tick(); load = 1'b0;
        for (int k = 1; k < 5; k++) tick();
        chk("t5_pre_cnt", 128'(cntout), 128'(3'd5));
        chk("t5_pre_ready", 128'(ready), 128'(1'b0));
        #2 rst = 1'b1;
        #1;
        chk_idle("t5_rst");
        chk("t5_rst_ready", 128'(ready), 128'(1'b1));
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (dout_valid) seen = seen + 1;
        end
        chk("t5_no_bits_after_rst", 128'(seen), 128'(0));

        // Loopback of random 128-bit words into the receive model.
        lb_din0 = {$urandom, $urandom, $urandom, $urandom};
        lb_din1 = {$urandom, $urandom, $urandom, $urandom};
        lb_din2 = {$urandom, $urandom, $urandom, $urandom};
        lb_din3 = {$urandom, $urandom, $urandom, $urandom};
        lb_load = 1'b1;
        tick(); lb_load = 1'b0;
        t = 0;
        while (!lb_last && t < 300) begin
            tick();
            t = t + 1;
        end
        chk("lb_last_seen", 128'(t < 300), 128'(1'b1));
        chk("lb_last_cnt", 128'(lb_cntout), 128'(7'd127));
        tick();
        chk("lb_lane0", rx0, lb_din0);
        chk("lb_lane1", rx1, lb_din1);
        chk("lb_lane2", rx2, lb_din2);
        chk("lb_lane3", rx3, lb_din3);
        chk("lb_idle_valid", 128'(lb_dout_valid), 128'(1'b0));
        chk("lb_idle_dout", 128'(lb_dout), 128'(4'b0001));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
